// File: rtl/hilo_div_seq.sv
// Sequential 32/32 divider for the MDU HI/LO pair.
// Restoring radix-2, one quotient bit per cycle.
module hilo_div_seq (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        signed_div,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        stall,
  output logic        done,
  output logic [63:0] result
);

  typedef enum logic [1:0] {
    IDLE,
    ZERO,
    RUN,
    DONE
  } state_t;

  state_t      state;
  logic [5:0]  cnt;
  logic [31:0] a_q;
  logic [31:0] dvd_q;
  logic [31:0] dvs_q;
  logic [31:0] rem_q;
  logic        neg_q;
  logic        neg_r;

  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [32:0] rem_sh;
  logic        q_bit;
  logic [31:0] rem_nxt;
  logic [31:0] quo_nxt;
  logic [31:0] q_fix;
  logic [31:0] r_fix;
  logic        is_idle;
  logic        busy;

  // Operand magnitudes; unsigned operands pass through untouched.
  always_comb begin
    abs_a = a;
    abs_b = b;
    if (signed_div && a[31]) begin
      abs_a = ~a + 32'd1;
    end
    if (signed_div && b[31]) begin
      abs_b = ~b + 32'd1;
    end
  end

  // One restoring step plus final sign fix-up of the step's outputs.
  always_comb begin
    rem_sh  = {rem_q, dvd_q[31]};
    q_bit   = (rem_sh >= {1'b0, dvs_q});
    rem_nxt = rem_sh[31:0];
    if (q_bit) begin
      rem_nxt = rem_sh[31:0] - dvs_q;
    end
    quo_nxt = {dvd_q[30:0], q_bit};
    q_fix   = quo_nxt;
    r_fix   = rem_nxt;
    if (neg_q) begin
      q_fix = ~quo_nxt + 32'd1;
    end
    if (neg_r) begin
      r_fix = ~rem_nxt + 32'd1;
    end
  end

  assign is_idle = (state == IDLE);
  assign busy    = (state == RUN) || (state == ZERO);

  // Pipeline hold: accepted request, running, or divide-by-zero.
  always_comb begin
    stall = 1'b0;
    if (resetn) begin
      stall = busy || (is_idle && start && !flush);
    end
  end

  // Control FSM and datapath registers; flush wins over everything but reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state  <= IDLE;
      cnt    <= 6'd0;
      a_q    <= 32'd0;
      dvd_q  <= 32'd0;
      dvs_q  <= 32'd0;
      rem_q  <= 32'd0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      result <= 64'd0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        state <= IDLE;
      end else begin
        unique case (state)
          IDLE: begin
            if (start) begin
              a_q   <= a;
              dvd_q <= abs_a;
              dvs_q <= abs_b;
              rem_q <= 32'd0;
              cnt   <= 6'd0;
              neg_q <= signed_div && (a[31] ^ b[31]);
              neg_r <= signed_div && a[31];
              state <= (b == 32'd0) ? ZERO : RUN;
            end
          end
          ZERO: begin
            result <= {a_q, 32'hFFFF_FFFF};
            done   <= 1'b1;
            state  <= DONE;
          end
          RUN: begin
            rem_q <= rem_nxt;
            dvd_q <= quo_nxt;
            cnt   <= cnt + 6'd1;
            if (cnt == 6'd31) begin
              result <= {r_fix, q_fix};
              done   <= 1'b1;
              state  <= DONE;
            end
          end
          DONE: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hilo_div_seq.sv
// Directed bench for hilo_div_seq.
// Hand-computed HI/LO results and cycle timing.
module tb_hilo_div_seq;

  logic        clk;
  logic        resetn;
  logic        start;
  logic        signed_div;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        stall;
  logic        done;
  logic [63:0] result;

  int n_checks;
  int n_errors;

  hilo_div_seq dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .signed_div (signed_div),
    .a          (a),
    .b          (b),
    .flush      (flush),
    .stall      (stall),
    .done       (done),
    .result     (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one divide; check stall span, latency, result, hold.
  task automatic do_div(input string tag,
                        input logic sg,
                        input logic [31:0] da,
                        input logic [31:0] db,
                        input int lat,
                        input logic [63:0] exp);
    int   n;
    logic st_ok;
    @(negedge clk);
    start      = 1'b1;
    signed_div = sg;
    a          = da;
    b          = db;
    #1;
    check({tag, " stall_k"}, 64'(stall), 64'd1);
    @(negedge clk);
    start = 1'b0;
    a     = 32'h1234_5678;
    b     = 32'h0;
    n     = 1;
    st_ok = 1'b1;
    while (!done && n < 40) begin
      if (!stall) st_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    check({tag, " latency"}, 64'(n), 64'(lat));
    check({tag, " stall_run"}, 64'(st_ok), 64'd1);
    check({tag, " stall_done"}, 64'(stall), 64'd0);
    check({tag, " result"}, result, exp);
    @(negedge clk);
    @(negedge clk);
    check({tag, " done_low"}, 64'(done), 64'd0);
    check({tag, " hold"}, result, exp);
  endtask

  // Watch a window for unwanted done pulses or stall.
  task automatic quiet(input string tag, input logic [63:0] exp);
    logic seen_done;
    logic seen_stall;
    seen_done  = 1'b0;
    seen_stall = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
      if (stall) seen_stall = 1'b1;
    end
    check({tag, " no_done"}, 64'(seen_done), 64'd0);
    check({tag, " no_stall"}, 64'(seen_stall), 64'd0);
    check({tag, " result"}, result, exp);
  endtask

  initial begin
    int d1;
    int d2;
    int n;
    logic s34;
    logic [63:0] r33;
    n_checks   = 0;
    n_errors   = 0;
    resetn     = 1'b0;
    start      = 1'b1;
    signed_div = 1'b0;
    a          = 32'd0;
    b          = 32'd0;
    flush      = 1'b0;

    repeat (3) @(negedge clk);
    check("rst stall", 64'(stall), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst result", result, 64'd0);
    start  = 1'b0;
    resetn = 1'b1;
    @(negedge clk);
    check("post_rst stall", 64'(stall), 64'd0);

    do_div("divu_100_7", 1'b0, 32'd100, 32'd7, 33, {32'd2, 32'd14});
    do_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 33,
           {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    do_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33,
           {32'h0000_0000, 32'h8000_0000});
    do_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 33,
           {32'd1, 32'hFFFF_FFFD});
    do_div("divu_big", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 33,
           {32'h8000_0000, 32'h0});
    do_div("divu_ff_16", 1'b0, 32'hFFFF_FFFF, 32'h10, 33,
           {32'hF, 32'h0FFF_FFFF});
    do_div("divu_by0", 1'b0, 32'd5, 32'd0, 2,
           {32'h5, 32'hFFFF_FFFF});
    do_div("div_m5_by0", 1'b1, 32'hFFFF_FFFB, 32'd0, 2,
           {32'hFFFF_FFFB, 32'hFFFF_FFFF});

    // flush and start together in IDLE
    @(negedge clk);
    start = 1'b1;
    flush = 1'b1;
    a     = 32'd100;
    b     = 32'd7;
    #1;
    check("idle_flush stall", 64'(stall), 64'd0);
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    quiet("idle_flush", {32'hFFFF_FFFB, 32'hFFFF_FFFF});

    // flush mid-run at k+10
    @(negedge clk);
    start      = 1'b1;
    signed_div = 1'b0;
    a          = 32'd100;
    b          = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("flush k10 stall", 64'(stall), 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush k11 stall", 64'(stall), 64'd0);
    quiet("flush_run", {32'hFFFF_FFFB, 32'hFFFF_FFFF});

    // reset mid-run at k+20
    @(negedge clk);
    start = 1'b1;
    a     = 32'd100;
    b     = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    resetn = 1'b0;
    start  = 1'b1;
    flush  = 1'b1;
    #1;
    check("rst_run stall", 64'(stall), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    start  = 1'b0;
    flush  = 1'b0;
    check("rst_run result", result, 64'd0);
    quiet("rst_run", 64'd0);

    // start held high: RUN/DONE starts ignored, next IDLE accepts
    @(negedge clk);
    start      = 1'b1;
    signed_div = 1'b0;
    a          = 32'd9;
    b          = 32'd3;
    n   = 0;
    d1  = 0;
    d2  = 0;
    s34 = 1'b0;
    r33 = 64'd0;
    while (n < 80 && d2 == 0) begin
      @(negedge clk);
      n++;
      if (done) begin
        if (d1 == 0) begin
          d1  = n;
          r33 = result;
        end else begin
          d2 = n;
        end
      end
      if (n == 34) s34 = stall;
    end
    start = 1'b0;
    check("b2b first_done", 64'(d1), 64'd33);
    check("b2b first_res", r33, {32'd0, 32'd3});
    check("b2b stall_k34", 64'(s34), 64'd1);
    check("b2b second_done", 64'(d2), 64'd67);
    check("b2b second_res", result, {32'd0, 32'd3});
    quiet("b2b_after", {32'd0, 32'd3});

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hilo_div_seq.md
HILO_DIV_SEQ -- requirements
Module: hilo_div_seq

Interface
REQ-001 The module SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-002 The module SHALL have port resetn, input, 1 bit: reset, synchronous and active-low.
REQ-003 The module SHALL have port start, input, 1 bit: request a divide; sampled only in IDLE.
REQ-004 The module SHALL have port signed_div, input, 1 bit: 1 selects DIV (signed), 0 selects DIVU (unsigned); sampled together with start.
REQ-005 The module SHALL have port a, input, 32 bits: dividend; sampled together with start.
REQ-006 The module SHALL have port b, input, 32 bits: divisor; sampled together with start.
REQ-007 The module SHALL have port flush, input, 1 bit: cancels any operation in progress (exception or pipeline flush).
REQ-008 The module SHALL have port stall, output, 1 bit: holds the pipeline while a divide is outstanding.
REQ-009 The module SHALL have port done, output, 1 bit: one-cycle pulse; result is valid.
REQ-010 The module SHALL have port result, output, 64 bits: {remainder -> HI[63:32], quotient -> LO[31:0]}.

Function
REQ-011 The module SHALL implement FSM states IDLE, ZERO, RUN and DONE.
REQ-012 In IDLE, start=1 with flush=0 SHALL latch a, b and signed_div, then go to RUN if b!=0 or to ZERO if b==0.
REQ-013 In IDLE, start=0 SHALL leave the FSM in IDLE.
REQ-014 RUN SHALL perform a radix-2 restoring divide of |a| by |b|, one quotient bit per cycle, using a 6-bit counter.
REQ-015 RUN SHALL last exactly 32 cycles and then go to DONE.
REQ-016 ZERO SHALL last 1 cycle and then go to DONE.
REQ-017 DONE SHALL last 1 cycle, with done=1, and then go to IDLE.
REQ-018 Timing: for start sampled at edge k, b!=0 SHALL give RUN in cycles k+1..k+32 and DONE in cycle k+33; b==0 SHALL give ZERO in cycle k+1 and DONE in cycle k+2.
REQ-019 stall SHALL be combinational: 1 when (IDLE and start and not flush), or in RUN, or in ZERO; 0 in DONE and in IDLE without start.
REQ-020 In the signed case, the magnitudes SHALL be computed in two's complement before the divide.
REQ-021 In the signed case, the quotient SHALL be negated when a[31]^b[31], and the remainder SHALL be negated when a[31].
REQ-022 In the unsigned case, operands SHALL be used as-is.
REQ-023 Signed overflow 0x80000000 / 0xFFFFFFFF SHALL yield quotient 0x80000000 and remainder 0 (natural wrap, no trap).
REQ-024 Divide by zero SHALL yield quotient 0xFFFFFFFF and remainder equal to the latched a, for both signed and unsigned.
REQ-025 result SHALL be updated only on entry to DONE, and SHALL hold its value until the next DONE.
REQ-026 Once DONE is reached, result SHALL remain stable through IDLE.
REQ-027 start asserted outside IDLE SHALL be ignored, with no queuing.
REQ-028 start asserted in the DONE cycle SHALL be ignored; a back-to-back divide is accepted from the following IDLE cycle.
REQ-029 flush=1 in any state SHALL force IDLE at the next edge; done is not pulsed and result is unchanged.
REQ-030 flush SHALL take priority over start; flush and start together in IDLE SHALL keep the FSM in IDLE.
REQ-031 In a DONE cycle with flush=1, done SHALL still be 1 in that cycle (the result is already final), and the next state SHALL be IDLE.

Reset
REQ-032 resetn=0 at a rising edge SHALL force IDLE, counter=0, result=0, latched operands=0, and done=0.
REQ-033 While resetn=0, stall SHALL be 0.
REQ-034 Reset SHALL override flush and start, and SHALL abort a divide in progress with no done pulse.

Verification
REQ-035 A bench SHALL cover unsigned divide: DIVU a=100, b=7 -> stall high cycles k..k+32, done in cycle k+33, result={32'd2, 32'd14}.
REQ-036 A bench SHALL cover signed divide: DIV a=-7 (0xFFFFFFF9), b=2 -> result={0xFFFFFFFF, 0xFFFFFFFD}; DIV a=0x80000000, b=0xFFFFFFFF -> result={0x00000000, 0x80000000}.
REQ-037 A bench SHALL cover divide by zero: DIVU a=5, b=0 -> done in cycle k+2, result={0x00000005, 0xFFFFFFFF}, stall high cycles k..k+1 only.
REQ-038 A bench SHALL cover flush mid-run: start 100/7, flush in cycle k+10 -> IDLE at k+11, stall 0 from k+11, no done, result keeps its prior value.
REQ-039 A bench SHALL cover reset mid-run: resetn=0 in cycle k+20 -> next cycle IDLE, result=0, done never pulses.
REQ-040 A bench SHALL cover ignored and back-to-back starts: start held high continuously with 9/3 -> start during RUN and DONE ignored; second divide accepted in IDLE cycle k+34, done at k+67, result={0, 3}.
